shift_seq_ctrl: RTL and testbench
=================================

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, shift register width in bits (WIDTH >= 2).
REQ-002 Parameter CNT_W, default $clog2(WIDTH)+1, width of the shift-amount field.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a shift operation; sampled only in IDLE.
REQ-006 abort  input  1  synchronous cancel of an operation in progress.
REQ-007 dir  input  1  0 = right shift (fill at MSB), 1 = left shift (fill at LSB).
REQ-008 rotate  input  1  1 = fill bit is the bit shifted out; 0 = fill bit is ser_in.
REQ-009 amount  input  CNT_W  number of single-bit shifts requested.
REQ-010 par_in  input  WIDTH  parallel load word.
REQ-011 ser_in  input  1  serial fill bit, sampled on every shift cycle.
REQ-012 par_out  output  WIDTH  current register contents.
REQ-013 ser_out  output  1  bit shifted out in the current shift cycle.
REQ-014 ser_vld  output  1  high on each shift cycle; qualifies ser_out.
REQ-015 busy  output  1  high in LOAD, SHIFT and DONE.
REQ-016 done  output  1  one-cycle pulse on normal completion.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, LOAD, SHIFT and DONE.
REQ-018 IDLE, start=1, abort=0: capture par_in, dir, rotate and amount (saturated to WIDTH) -> LOAD.
REQ-019 LOAD lasts one cycle: register holds par_in; next state is DONE if the captured amount is 0, otherwise SHIFT.
REQ-020 Each SHIFT cycle SHALL shift exactly once: right = {fill, q[WIDTH-1:1]}, left = {q[WIDTH-2:0], fill}.
REQ-021 Fill bit: rotate=1 -> q[0] for a right shift, q[WIDTH-1] for a left shift; rotate=0 -> ser_in.
REQ-022 In SHIFT, ser_out SHALL equal the outgoing bit (q[0] right, q[WIDTH-1] left) and ser_vld=1; outside SHIFT, ser_vld=0 and ser_out=0.
REQ-023 A remaining counter loaded with the amount SHALL decrement per shift; the shift with remaining=1 transitions to DONE.
REQ-024 DONE lasts one cycle with done=1, then returns to IDLE; total start-to-done latency = amount+2 cycles (2 for amount 0).
REQ-025 start SHALL be ignored outside IDLE; dir/rotate/amount changes during an operation have no effect.
REQ-026 abort in LOAD or SHIFT -> IDLE next edge, no done pulse, par_out holds the partially shifted value.
REQ-027 abort in IDLE or DONE has no effect; abort and start together in IDLE -> abort wins, no capture.
REQ-028 par_out SHALL hold its value in IDLE until the next accepted start.
REQ-029 amount > WIDTH SHALL be clamped to WIDTH (rotate by WIDTH returns the original word).

Reset
REQ-030 rst=0 SHALL immediately force IDLE, par_out=0, remaining=0, busy=0, done=0, ser_vld=0 and ser_out=0, independent of clk.
REQ-031 Reset asserted mid-operation SHALL discard the operation without a done pulse; the first start after deassertion behaves normally.

Structure
REQ-032 The state encoding (IDLE, LOAD, SHIFT, DONE) and the direction constants (SHIFT_RIGHT=0, SHIFT_LEFT=1) SHALL be defined in a shared package, shift_pkg.
REQ-033 The datapath SHALL be one sub-module, shift_reg_core (WIDTH-parametric; load, enable, direction and fill inputs), driven by the FSM.

Verification
REQ-034 WIDTH=8, par_in=8'hB4, dir=0, rotate=0, ser_in=1, amount=3 -> done 5 cycles after start, par_out=8'hF6, ser_out stream 0,0,1.
REQ-035 par_in=8'h81, dir=1, rotate=1, amount=1 -> par_out=8'h03, ser_out=1; then amount=12 on 8'hA5 -> clamped to 8, par_out=8'hA5.
REQ-036 amount=0, par_in=8'h5A -> done 2 cycles after start, par_out=8'h5A, ser_vld never asserted.
REQ-037 amount=6, abort asserted in the 3rd SHIFT cycle -> IDLE next edge, no done, par_out equals the value after 3 shifts.
REQ-038 rst driven low between clock edges mid-SHIFT -> all outputs 0 immediately; start with 8'h0F after release -> normal completion.
REQ-039 start held high through a full operation -> exactly one operation per IDLE visit, back-to-back with one IDLE cycle between done and the next LOAD.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer: FSM state encoding and
// direction constants used by both the controller and the datapath.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic SHIFT_RIGHT = 1'b0;
  localparam logic SHIFT_LEFT  = 1'b1;

endpackage

// File: rtl/shift_reg_core.sv
// Parallel-load shift register datapath; one single-bit shift per enabled cycle.
module shift_reg_core
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enable,
  input  logic             dir,
  input  logic             fill,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] shifted
);

  // The shifted word is exported so the controller can pre-compute the next outgoing bit.
  assign shifted = (dir == SHIFT_LEFT) ? {q[WIDTH-2:0], fill} : {fill, q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (enable) begin
      q <= shifted;
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Shift sequencer: captures a word and shift request in IDLE, then performs
// one shift per cycle with registered serial/status outputs.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             dir,
  input  logic             rotate,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in,
  output logic [WIDTH-1:0] par_out,
  output logic             ser_out,
  output logic             ser_vld,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] amt_sat;
  logic             dir_r;
  logic             rot_r;
  logic             load_en;
  logic             shift_en;
  logic             fill;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] shifted;

  assign amt_sat  = (amount > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amount;
  assign load_en  = (state == IDLE) && start && !abort;
  assign shift_en = (state == SHIFT);
  assign fill     = rot_r ? ((dir_r == SHIFT_LEFT) ? q[WIDTH-1] : q[0]) : ser_in;
  assign par_out  = q;

  shift_reg_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .load    (load_en),
    .enable  (shift_en),
    .dir     (dir_r),
    .fill    (fill),
    .d       (par_in),
    .q       (q),
    .shifted (shifted)
  );

  // ser_out is registered, so it is loaded with the bit that will leave during the next SHIFT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
      dir_r     <= SHIFT_RIGHT;
      rot_r     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ser_vld   <= 1'b0;
      ser_out   <= 1'b0;
    end else begin
      done    <= 1'b0;
      ser_vld <= 1'b0;
      ser_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state     <= LOAD;
            dir_r     <= dir;
            rot_r     <= rotate;
            remaining <= amt_sat;
            busy      <= 1'b1;
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (remaining == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state   <= SHIFT;
            ser_vld <= 1'b1;
            ser_out <= (dir_r == SHIFT_LEFT) ? q[WIDTH-1] : q[0];
          end
        end
        SHIFT: begin
          remaining <= remaining - CNT_W'(1);
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (remaining == CNT_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            ser_vld <= 1'b1;
            ser_out <= (dir_r == SHIFT_LEFT) ? shifted[WIDTH-1] : shifted[0];
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared cycle-by-cycle to a phase-count model.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, dir, rotate, ser_in;
  logic [3:0] amount;
  logic [7:0] par_in;
  logic [7:0] par_out;
  logic       ser_out, ser_vld, busy, done;

  int tests = 0;
  int fails = 0;

  // Model: k counts cycles since acceptance (0 = idle); n is the clamped amount.
  int         k = 0;
  int         n = 0;
  logic [7:0] word = 8'h00;
  logic       m_dir = 1'b0;
  logic       m_rot = 1'b0;
  logic       fb;

  shift_seq_ctrl #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .dir     (dir),
    .rotate  (rotate),
    .amount  (amount),
    .par_in  (par_in),
    .ser_in  (ser_in),
    .par_out (par_out),
    .ser_out (ser_out),
    .ser_vld (ser_vld),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      k    = 0;
      n    = 0;
      word = 8'h00;
    end else if (k == 0) begin
      if (start && !abort) begin
        word  = par_in;
        n     = (amount > 4'd8) ? 8 : int'(amount);
        m_dir = dir;
        m_rot = rotate;
        k     = 1;
      end
    end else if (k == n + 2) begin
      k = 0;
    end else begin
      if (k >= 2) begin
        fb   = m_rot ? (m_dir ? word[7] : word[0]) : ser_in;
        word = m_dir ? ((word << 1) | 8'(fb)) : ((word >> 1) | (8'(fb) << 7));
      end
      k = abort ? 0 : k + 1;
    end
  end

  always @(negedge clk) begin
    logic exp_vld;
    exp_vld = (k >= 2) && (k <= n + 1);
    check_output("model par_out", par_out, word);
    check_output("model busy", 8'(busy), 8'(k != 0));
    check_output("model done", 8'(done), 8'((k != 0) && (k == n + 2)));
    check_output("model ser_vld", 8'(ser_vld), 8'(exp_vld));
    check_output("model ser_out", 8'(ser_out), 8'(exp_vld ? (m_dir ? word[7] : word[0]) : 1'b0));
  end

  task automatic apply_stimulus(input logic [7:0] p, input logic d, input logic r, input logic [3:0] a,
                                input logic s, output int lat, output logic [7:0] res,
                                output logic [7:0] stream, output int nvld);
    @(negedge clk);
    par_in = p; dir = d; rotate = r; amount = a; ser_in = s; start = 1'b1;
    lat = 0; stream = 8'h00; nvld = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (ser_vld) begin
        stream = {stream[6:0], ser_out};
        nvld++;
      end
    end while (!done && lat < 40);
    res = par_out;
  endtask

  initial begin
    int         lat, nvld, ndone, nidle;
    logic [7:0] res, stream;
    rst = 1'b0; start = 1'b0; abort = 1'b0; dir = 1'b0; rotate = 1'b0;
    amount = 4'd0; par_in = 8'h00; ser_in = 1'b0;
    #3;
    check_output("reset par_out", par_out, 8'h00);
    check_output("reset busy", 8'(busy), 8'h00);
    check_output("reset done", 8'(done), 8'h00);
    check_output("reset ser_vld", 8'(ser_vld), 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    apply_stimulus(8'hB4, 1'b0, 1'b0, 4'd3, 1'b1, lat, res, stream, nvld);
    check_output("right3 latency", 8'(lat), 8'd5);
    check_output("right3 par_out", res, 8'hF6);
    check_output("right3 stream", stream, 8'h01);
    check_output("right3 nvld", 8'(nvld), 8'd3);

    apply_stimulus(8'h81, 1'b1, 1'b1, 4'd1, 1'b0, lat, res, stream, nvld);
    check_output("rotl1 par_out", res, 8'h03);
    check_output("rotl1 ser_out", stream, 8'h01);
    check_output("rotl1 latency", 8'(lat), 8'd3);

    apply_stimulus(8'hA5, 1'b1, 1'b1, 4'd12, 1'b0, lat, res, stream, nvld);
    check_output("clamp latency", 8'(lat), 8'd10);
    check_output("clamp par_out", res, 8'hA5);

    apply_stimulus(8'h5A, 1'b0, 1'b0, 4'd0, 1'b1, lat, res, stream, nvld);
    check_output("zero latency", 8'(lat), 8'd2);
    check_output("zero par_out", res, 8'h5A);
    check_output("zero nvld", 8'(nvld), 8'd0);

    // Abort during the third shift: that shift still lands, then back to IDLE.
    @(negedge clk);
    par_in = 8'hB4; dir = 1'b0; rotate = 1'b0; amount = 4'd6; ser_in = 1'b0; start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    check_output("abort pre ser_vld", 8'(ser_vld), 8'h01);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_output("abort busy", 8'(busy), 8'h00);
    check_output("abort done", 8'(done), 8'h00);
    check_output("abort par_out", par_out, 8'h16);

    // Reset dropped between edges mid-shift.
    @(negedge clk);
    par_in = 8'h0F; dir = 1'b0; rotate = 1'b0; amount = 4'd5; ser_in = 1'b1; start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    check_output("async par_out", par_out, 8'h00);
    check_output("async busy", 8'(busy), 8'h00);
    check_output("async ser_vld", 8'(ser_vld), 8'h00);
    check_output("async ser_out", 8'(ser_out), 8'h00);
    check_output("async done", 8'(done), 8'h00);
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(8'h0F, 1'b0, 1'b1, 4'd4, 1'b0, lat, res, stream, nvld);
    check_output("post-reset latency", 8'(lat), 8'd6);
    check_output("post-reset par_out", res, 8'hF0);

    // start held high: LOAD, SHIFT, DONE, IDLE repeating.
    @(negedge clk);
    par_in = 8'h33; dir = 1'b1; rotate = 1'b1; amount = 4'd1; start = 1'b1;
    ndone = 0; nidle = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
      if (!busy) nidle++;
    end
    start = 1'b0;
    check_output("held start dones", 8'(ndone), 8'd3);
    check_output("held start idles", 8'(nidle), 8'd3);
    repeat (12) @(negedge clk);

    repeat (800) begin
      @(negedge clk);
      start  = ($urandom_range(0, 2) == 0);
      abort  = ($urandom_range(0, 19) == 0);
      dir    = 1'($urandom);
      rotate = 1'($urandom);
      amount = 4'($urandom_range(0, 15));
      par_in = 8'($urandom);
      ser_in = 1'($urandom);
    end
    start = 1'b0; abort = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
